// File: rtl/tf_rom_seq.sv
// tf_rom_seq: sequencer for the twiddle-factor ROM in the mixed-radix NTT datapath.
//
// A start pulse launches a job that reads cfg_len consecutive ROM entries. The read
// window begins at cfg_base and wraps at ROM_DEPTH. Each word is presented cfg_rep
// times on a valid/ready stream. The ROM has a 1-cycle registered read gated by
// rom_en, and its Q register holds while rom_en is low. That Q register is the data
// register of the stream. This block only drives the address and enable lines, plus
// the tf_valid/tf_last qualifiers, which line up with Q.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle job request, sampled only when idle
//   cfg_base            first ROM address; values >= ROM_DEPTH fall back to 0
//   cfg_len             number of distinct words to read; 0 completes at once
//   cfg_rep             beats per word; 0 is treated as 1
//   rom_addr, rom_en    ROM A and IREN
//   tf_valid, tf_ready  stream handshake qualifying ROM Q
//   tf_last             current beat is the final beat of the job
//   busy, done          job in progress / one-cycle completion pulse
module tf_rom_seq #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned ROM_DEPTH = 43,
    parameter int unsigned LEN_W     = 7,
    parameter int unsigned REP_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [REP_W-1:0]  cfg_rep,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    output logic              tf_valid,
    input  logic              tf_ready,
    output logic              tf_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] AddrMax = ADDR_W'(ROM_DEPTH - 1);
    localparam logic [REP_W-1:0]  RepOne  = REP_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [LEN_W-1:0]  issue_left_q, issue_left_d;
    logic [REP_W-1:0]  rep_eff_q, rep_eff_d;
    logic [REP_W-1:0]  rep_left_q, rep_left_d;
    logic              tf_valid_q, tf_valid_d;
    logic              tf_last_q, tf_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              handshake;
    logic              free;

    assign handshake = tf_valid_q && tf_ready;
    // Q may be overwritten when it is empty or its final beat is being accepted now.
    assign free      = !tf_valid_q || (tf_ready && (rep_left_q == RepOne));
    assign rom_en    = (state_q == StRun) && (issue_left_q != '0) && free;

    always_comb begin
        state_d      = state_q;
        addr_cnt_d   = addr_cnt_q;
        issue_left_d = issue_left_q;
        rep_eff_d    = rep_eff_q;
        rep_left_d   = rep_left_q;
        tf_valid_d   = tf_valid_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_cnt_d   = (cfg_base > AddrMax) ? '0 : cfg_base;
                    issue_left_d = cfg_len;
                    rep_eff_d    = (cfg_rep == '0) ? RepOne : cfg_rep;
                    rep_left_d   = '0;
                    tf_valid_d   = 1'b0;
                    state_d      = (cfg_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (rom_en) begin
                    // New word lands in Q next cycle; this also covers back-to-back reloads.
                    addr_cnt_d   = (addr_cnt_q == AddrMax) ? '0 : addr_cnt_q + ADDR_W'(1);
                    issue_left_d = issue_left_q - LEN_W'(1);
                    tf_valid_d   = 1'b1;
                    rep_left_d   = rep_eff_q;
                end else if (handshake) begin
                    if (rep_left_q > RepOne) begin
                        rep_left_d = rep_left_q - RepOne;
                    end else begin
                        tf_valid_d = 1'b0;
                        rep_left_d = '0;
                        if (tf_last_q) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        tf_last_d = tf_valid_d && (issue_left_d == '0) && (rep_left_d == RepOne);
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_cnt_q   <= '0;
            issue_left_q <= '0;
            rep_eff_q    <= '0;
            rep_left_q   <= '0;
            tf_valid_q   <= 1'b0;
            tf_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_cnt_q   <= addr_cnt_d;
            issue_left_q <= issue_left_d;
            rep_eff_q    <= rep_eff_d;
            rep_left_q   <= rep_left_d;
            tf_valid_q   <= tf_valid_d;
            tf_last_q    <= tf_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign rom_addr = addr_cnt_q;
    assign tf_valid = tf_valid_q;
    assign tf_last  = tf_last_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tf_rom_seq.sv
// Testbench for tf_rom_seq. It contains a ROM model with random contents.
// Expected beats come from the job description: word i is entry
// (base_eff + i) mod 43, presented rep_eff times.
module tb_tf_rom_seq;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 43;
    localparam int LEN_W  = 7;
    localparam int REP_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [REP_W-1:0]  cfg_rep = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic              tf_valid;
    logic              tf_ready = 1'b0;
    logic              tf_last;
    logic              busy;
    logic              done;

    logic [35:0] rom_img [DEPTH];
    logic [35:0] q;

    int n_vec = 0;
    int n_bad = 0;

    tf_rom_seq #(
        .ADDR_W   (ADDR_W),
        .ROM_DEPTH(DEPTH),
        .LEN_W    (LEN_W),
        .REP_W    (REP_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cfg_base(cfg_base),
        .cfg_len (cfg_len),
        .cfg_rep (cfg_rep),
        .rom_addr(rom_addr),
        .rom_en  (rom_en),
        .tf_valid(tf_valid),
        .tf_ready(tf_ready),
        .tf_last (tf_last),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // ROM: registered read gated by IREN, Q holds otherwise.
    always_ff @(posedge clk) begin
        if (rom_en) begin
            q <= (int'(rom_addr) < DEPTH) ? rom_img[rom_addr] : 'x;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_of(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one job and checks it against the job-level model.
    // mode: 0 ready always 1, 1 pattern 1,0,0, 2 random.
    task automatic run_job(input int base, input int len, input int rep, input int mode,
                           input bit mid_start, input int exp_done_cyc);
        int base_eff, rep_eff, total, beats, reads, cyc, first_valid, budget, idx;
        bit finished;
        base_eff    = (base >= DEPTH) ? 0 : base;
        rep_eff     = (rep == 0) ? 1 : rep;
        total       = len * rep_eff;
        beats       = 0;
        reads       = 0;
        cyc         = 0;
        first_valid = -1;
        budget      = total * 4 + 20;
        finished    = 1'b0;

        @(negedge clk);
        cfg_base = ADDR_W'(base);
        cfg_len  = LEN_W'(len);
        cfg_rep  = REP_W'(rep);
        start    = 1'b1;
        tf_ready = ready_of(mode, 0);

        while (!finished) begin
            @(negedge clk);
            cyc++;
            start = mid_start && (cyc == 3);
            if (mid_start && cyc == 3) begin
                cfg_base = ADDR_W'($urandom_range(0, 63));
                cfg_len  = LEN_W'($urandom_range(1, 127));
                cfg_rep  = REP_W'($urandom_range(0, 15));
            end
            tf_ready = ready_of(mode, cyc);
            #1;
            if (cyc == 1) check("busy_in_job", 64'(busy), 64'd1);
            if (rom_en) begin
                check("rom_addr", 64'(rom_addr), 64'((base_eff + reads) % DEPTH));
                check("en_during_stall", 64'(tf_valid && !tf_ready), 64'd0);
                reads++;
            end
            if (tf_valid) begin
                if (first_valid < 0) first_valid = cyc;
                idx = beats / rep_eff;
                check("q_word", 64'(q), 64'(rom_img[(base_eff + idx) % DEPTH]));
                check("tf_last", 64'(tf_last), 64'(beats == total - 1));
                if (tf_ready) beats++;
            end else begin
                check("tf_last_idle", 64'(tf_last), 64'd0);
            end
            if (done) begin
                check("done_no_valid", 64'(tf_valid), 64'd0);
                finished = 1'b1;
            end else if (cyc >= budget) begin
                check("done_timeout", 64'(cyc), 64'(-1));
                finished = 1'b1;
            end
        end

        check("beat_count", 64'(beats), 64'(total));
        check("read_count", 64'(reads), 64'(len));
        check("first_valid_cyc", 64'(first_valid), 64'((len > 0) ? 2 : -1));
        if (exp_done_cyc >= 0) check("done_cyc", 64'(cyc), 64'(exp_done_cyc));
        start = 1'b0;
        @(negedge clk);
        #1;
        check("done_pulse_end", 64'(done), 64'd0);
        check("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            rom_img[i] = {4'($urandom), $urandom};
        end

        #1;
        check("rst_addr", 64'(rom_addr), 64'd0);
        check("rst_en", 64'(rom_en), 64'd0);
        check("rst_valid", 64'(tf_valid), 64'd0);
        check("rst_busy_done", 64'({busy, done, tf_last}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_job(0, 3, 1, 0, 1'b0, 5);      // basic stream
        run_job(10, 2, 4, 0, 1'b0, 10);    // repeat
        run_job(5, 4, 2, 1, 1'b0, -1);     // backpressure
        run_job(41, 4, 1, 0, 1'b0, 6);     // wrap
        run_job(50, 3, 1, 0, 1'b0, 5);     // base clamp
        run_job(7, 0, 3, 0, 1'b0, 1);      // len = 0
        run_job(20, 5, 0, 0, 1'b0, 7);     // rep = 0
        run_job(0, 6, 2, 2, 1'b1, -1);     // start mid-job

        // Reset mid-job.
        @(negedge clk);
        cfg_base = 6'd3;
        cfg_len  = 7'd20;
        cfg_rep  = 4'd2;
        start    = 1'b1;
        tf_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs",
              64'({rom_addr, rom_en, tf_valid, tf_last, busy, done}), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("midrst_no_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        run_job(1, 3, 2, 0, 1'b0, 8);

        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(0, 63)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 15)), 2, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tf_rom_seq.md
Name: tf_rom_seq

Overview:
- Sequencer for the twiddle-factor ROM (36-bit words, 1-cycle registered read gated by IREN, Q holds while IREN low) in the mixed-radix NTT datapath.
- On a start pulse it reads a configured window of consecutive ROM entries and presents each word to the butterfly as a valid/ready stream. Each word is presented a configurable number of times.
- The ROM Q register is the output data register. This block drives A/IREN and generates tf_valid/tf_last aligned to Q.

Parameters:
ADDR_W, 6, ROM address width
ROM_DEPTH, 43, number of valid ROM entries; addresses wrap at this value
LEN_W, 7, width of word-count field
REP_W, 4, width of repeat-count field

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
cfg_base  in  ADDR_W  first ROM address
cfg_len  in  LEN_W  number of distinct words to read
cfg_rep  in  REP_W  beats per word; 0 treated as 1
rom_addr  out  ADDR_W  to ROM A
rom_en  out  1  to ROM IREN
tf_valid  out  1  ROM Q holds a deliverable twiddle
tf_ready  in  1  butterfly accepts current beat
tf_last  out  1  current beat is the final beat of the job
busy  out  1  job in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rom_addr=0, rom_en=0, tf_valid=0, tf_last=0, busy=0, done=0.
  - All counters are cleared.
  - Reset mid-job abandons the job with no done pulse.
  - ROM Q content is don't-care after reset.
- States: IDLE, RUN, DONE. busy=1 in RUN and DONE. done=1 only in DONE. DONE always returns to IDLE the next cycle.
- IDLE with start=1:
  - Latch addr_cnt = cfg_base, or 0 if cfg_base >= ROM_DEPTH.
  - Latch issue_left = cfg_len and rep_eff = max(cfg_rep, 1).
  - cfg_len=0 → go to DONE: done asserts the cycle after start; rom_en is never asserted.
  - Otherwise go to RUN.
- start in RUN or DONE is ignored. Config is not re-sampled.
- rom_addr = addr_cnt (registered).
- rom_en is combinational:
  - free = !tf_valid || (tf_ready && rep_left==1)
  - rom_en = (state==RUN) && issue_left>0 && free
  - tf_ready→rom_en is a permitted combinational path.
- On rom_en at edge t:
  - addr_cnt increments, wrapping ROM_DEPTH-1 → 0.
  - issue_left decrements.
  - At t+1: tf_valid=1, rep_left=rep_eff, and Q holds the word.
- Handshake (tf_valid && tf_ready):
  - rep_left>1: rep_left decrements; tf_valid stays 1; Q is unchanged (no read).
  - rep_left==1 with a read issued in the same cycle: tf_valid stays 1 (back-to-back, no bubble).
  - rep_left==1 with no read: tf_valid drops.
- Stall: tf_valid=1 with tf_ready=0 → rom_en=0, Q/tf_valid/tf_last hold.
- tf_last = tf_valid && issue_left==0 && rep_left==1.
- Completion: a handshake with tf_last=1 → next cycle DONE (tf_valid=0, done=1), then IDLE.
- Throughput: with tf_ready held 1, one beat per cycle. First valid beat appears 2 cycles after start (IDLE→RUN, read, Q).
- Total beats per job = cfg_len × rep_eff. ROM reads per job = cfg_len exactly.

Test Plan:
1. Basic stream:
   - Stimulus: base=0, len=3, rep=1, tf_ready=1.
   - Required: rom_en high 3 consecutive cycles with rom_addr 0,1,2; tf_valid 3 consecutive cycles with Q = entries 0,1,2; tf_last on beat 3; done one cycle later, then busy=0.
2. Repeat:
   - Stimulus: base=10, len=2, rep=4, tf_ready=1.
   - Required: 8 beats (entry 10 ×4, entry 11 ×4); exactly 2 rom_en pulses; tf_last only on beat 8.
3. Backpressure:
   - Stimulus: base=5, len=4, rep=2, tf_ready toggling 1,0,0,1,….
   - Required: Q stable whenever tf_valid && !tf_ready; rom_en never high during stall; 8 accepted beats in order 5,5,6,6,7,7,8,8.
4. Wrap and base clamp:
   - Stimulus: base=41, len=4.
   - Required: rom_addr 41,42,0,1.
   - Stimulus: separate job with base=50.
   - Required: reads start at 0.
5. Degenerate config:
   - Stimulus: len=0.
   - Required: done 1 cycle after start, no rom_en, no tf_valid.
   - Stimulus: rep=0.
   - Required: behaves as rep=1.
6. Control:
   - Stimulus: start pulsed mid-job.
   - Required: ignored; beat count unchanged.
   - Stimulus: rst_n low mid-job.
   - Required: all outputs 0 immediately, no done; a new start after release runs a clean job.
